// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, line levels and baud divider.
// Used by the transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LINE = 1'b1;

  function automatic int baud_div(
    input int clk_frq,
    input int baud_rate
  );
    return clk_frq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter 0..BAUD_DIV-1; restart realigns it to a new frame.
// tick marks the last cycle of a bit; tick_next predicts it one cycle early.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 16
) (
  input  logic clk,
  input  logic areset_n,
  input  logic restart,
  output logic tick,
  output logic tick_next
);

  localparam int W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(BAUD_DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Wrap at the last count; a restart forces the count back to zero.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) cnt_d = '0;
    if (restart) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!areset_n) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign tick      = (cnt_q == LAST);
  assign tick_next = (cnt_d == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, BYTE data bits LSB first, stop bit.
// Define UART_TX_PARITY_EN to insert an even parity bit before stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FRQ   = 250000000,
  parameter int BAUD_RATE = 115200,
  parameter int BYTE      = 8
) (
  input  logic            clk,
  input  logic            areset_n,
  input  logic            tx_valid,
  input  logic [BYTE-1:0] tx_data,
  output logic            tx_ready,
  output logic            data_out,
  output logic            tx_busy,
  output logic            tx_done
);

  localparam int BAUD_DIV = baud_div(CLK_FRQ, BAUD_RATE);
  localparam int BW = (BYTE > 1) ? $clog2(BYTE) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(BYTE - 1);

  if (BAUD_DIV < 2 || BYTE < 1) begin : g_bad_cfg
    $error("uart_tx: need BAUD_DIV >= 2 and BYTE >= 1");
  end

  state_e          state_q, state_d;
  logic [BYTE-1:0] shift_q, shift_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            line_q, line_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            hs;
  logic            tick;
  logic            tick_next;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  assign hs = tx_valid & rdy_q;

  uart_baud_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk      (clk),
    .areset_n (areset_n),
    .restart  (hs),
    .tick     (tick),
    .tick_next(tick_next)
  );

  // Next-state logic; outputs derive from the next state so they can be registered.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          shift_d = tx_data;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    line_d = IDLE_LINE;
    unique case (state_d)
      START:   line_d = START_BIT;
      DATA:    line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_d = par_d;
`endif
      STOP:    line_d = STOP_BIT;
      default: line_d = IDLE_LINE;
    endcase

    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && tick_next;
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      line_q  <= IDLE_LINE;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      line_q  <= line_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx_ready = rdy_q;
  assign data_out = line_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at BAUD_DIV=16, BYTE=8.
// Frames are predicted from the bit list of each byte; a line decoder checks loopback.
module tb_uart_tx;

  localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FLEN = NB * DIV;
  localparam int P = FLEN + 1;

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       data_out;
  logic       tx_busy;
  logic       tx_done;

  int nchk = 0;
  int nfail = 0;

  logic       mon_en = 1'b0;
  logic [7:0] rx_q[$];
  int         rx_ferr = 0;
  int         done_cnt = 0;

  uart_tx #(
    .CLK_FRQ(16),
    .BAUD_RATE(1),
    .BYTE(8)
  ) dut (
    .clk     (clk),
    .areset_n(areset_n),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .data_out(data_out),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == NB - 1) return 1'b1;
    return ^b;
  endfunction

  // Independent line decoder: mid-bit sampling after each falling edge.
  initial begin : monitor
    logic prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (mon_en && prev && !data_out) begin
        repeat (7) @(posedge clk);
        #1;
        if (data_out !== 1'b0) rx_ferr++;
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(posedge clk);
          #1;
          b[i] = data_out;
        end
`ifdef UART_TX_PARITY_EN
        repeat (16) @(posedge clk);
        #1;
        if (data_out !== ^b) rx_ferr++;
`endif
        repeat (16) @(posedge clk);
        #1;
        if (data_out !== 1'b1) rx_ferr++;
        rx_q.push_back(b);
      end
      prev = data_out;
    end
  end

  always @(posedge clk) begin
    #1;
    if (mon_en && tx_done === 1'b1) done_cnt++;
  end

  task automatic test_reset();
    areset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if (data_out !== 1'b1) begin
      nfail++; $display("FAIL reset_line got %b want 1", data_out);
    end
    nchk++;
    if (tx_ready !== 1'b1) begin
      nfail++; $display("FAIL reset_ready got %b want 1", tx_ready);
    end
    nchk++;
    if (tx_busy !== 1'b0) begin
      nfail++; $display("FAIL reset_busy got %b want 0", tx_busy);
    end
    nchk++;
    if (tx_done !== 1'b0) begin
      nfail++; $display("FAIL reset_done got %b want 0", tx_done);
    end
    areset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [7:0] b;
    logic el;
    b = 8'hA5;
    tx_data = b;
    tx_valid = 1'b1;
    for (int k = 1; k <= P + 2; k++) begin
      @(posedge clk); #1;
      if (k == 1) tx_valid = 1'b0;
      el = (k <= FLEN) ? frame_bit(b, (k - 1) / DIV) : 1'b1;
      nchk++;
      if (data_out !== el) begin
        nfail++; $display("FAIL single_line k=%0d got %b want %b", k, data_out, el);
      end
      nchk++;
      if (tx_done !== (k == FLEN)) begin
        nfail++; $display("FAIL single_done k=%0d got %b want %b", k, tx_done, k == FLEN);
      end
      nchk++;
      if (tx_ready !== (k >= P)) begin
        nfail++; $display("FAIL single_ready k=%0d got %b want %b", k, tx_ready, k >= P);
      end
      nchk++;
      if (tx_busy !== (k < P)) begin
        nfail++; $display("FAIL single_busy k=%0d got %b want %b", k, tx_busy, k < P);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic el;
    int f, j, dn;
    dn = 0;
    tx_data = 8'h00;
    tx_valid = 1'b1;
    for (int k = 1; k <= 2 * P; k++) begin
      @(posedge clk); #1;
      if (k == 1) tx_data = 8'hFF;
      if (k == P + 1) tx_valid = 1'b0;
      f = (k - 1) / P;
      j = (k - 1) % P + 1;
      b = (f == 0) ? 8'h00 : 8'hFF;
      el = (j <= FLEN) ? frame_bit(b, (j - 1) / DIV) : 1'b1;
      if (tx_done === 1'b1) dn++;
      nchk++;
      if (data_out !== el) begin
        nfail++; $display("FAIL b2b_line k=%0d got %b want %b", k, data_out, el);
      end
      nchk++;
      if (tx_done !== (j == FLEN)) begin
        nfail++; $display("FAIL b2b_done k=%0d got %b want %b", k, tx_done, j == FLEN);
      end
      nchk++;
      if (tx_ready !== (j == P)) begin
        nfail++; $display("FAIL b2b_ready k=%0d got %b want %b", k, tx_ready, j == P);
      end
    end
    nchk++;
    if (dn != 2) begin
      nfail++; $display("FAIL b2b_done_count got %0d want 2", dn);
    end
  endtask

  task automatic test_ignore_valid();
    logic [7:0] b;
    logic el;
    b = 8'($urandom_range(0, 255));
    tx_data = b;
    tx_valid = 1'b1;
    for (int k = 1; k <= P + 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) tx_valid = 1'b0;
      el = (k <= FLEN) ? frame_bit(b, (k - 1) / DIV) : 1'b1;
      nchk++;
      if (data_out !== el) begin
        nfail++; $display("FAIL ignore_line k=%0d got %b want %b", k, data_out, el);
      end
      nchk++;
      if (tx_done !== (k == FLEN)) begin
        nfail++; $display("FAIL ignore_done k=%0d got %b want %b", k, tx_done, k == FLEN);
      end
      if (k == 60) begin
        tx_data = 8'h3C;
        tx_valid = 1'b1;
      end
      if (k == 61) tx_valid = 1'b0;
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    logic el;
    b = 8'($urandom_range(0, 255));
    tx_data = b;
    tx_valid = 1'b1;
    for (int k = 1; k <= 81; k++) begin
      @(posedge clk); #1;
      if (k == 1) tx_valid = 1'b0;
      el = frame_bit(b, (k - 1) / DIV);
      nchk++;
      if (data_out !== el) begin
        nfail++; $display("FAIL rstmid_line k=%0d got %b want %b", k, data_out, el);
      end
    end
    areset_n = 1'b0;
    @(posedge clk); #1;
    areset_n = 1'b1;
    nchk++;
    if (data_out !== 1'b1) begin
      nfail++; $display("FAIL rstmid_line_after got %b want 1", data_out);
    end
    nchk++;
    if (tx_ready !== 1'b1) begin
      nfail++; $display("FAIL rstmid_ready_after got %b want 1", tx_ready);
    end
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      nchk++;
      if (tx_done !== 1'b0 || data_out !== 1'b1) begin
        nfail++; $display("FAIL rstmid_quiet k=%0d done=%b line=%b want 0/1", k, tx_done, data_out);
      end
    end
    b = 8'h81;
    tx_data = b;
    tx_valid = 1'b1;
    for (int k = 1; k <= P; k++) begin
      @(posedge clk); #1;
      if (k == 1) tx_valid = 1'b0;
      el = (k <= FLEN) ? frame_bit(b, (k - 1) / DIV) : 1'b1;
      nchk++;
      if (data_out !== el) begin
        nfail++; $display("FAIL rst81_line k=%0d got %b want %b", k, data_out, el);
      end
      nchk++;
      if (tx_done !== (k == FLEN)) begin
        nfail++; $display("FAIL rst81_done k=%0d got %b want %b", k, tx_done, k == FLEN);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    tx_data = 8'h07;
    tx_valid = 1'b1;
    for (int k = 1; k <= P; k++) begin
      @(posedge clk); #1;
      if (k == 1) tx_valid = 1'b0;
      if (k > 9 * DIV && k <= 10 * DIV) begin
        nchk++;
        if (data_out !== 1'b1) begin
          nfail++; $display("FAIL parity_bit k=%0d got %b want 1", k, data_out);
        end
      end
      nchk++;
      if (tx_done !== (k == 176)) begin
        nfail++; $display("FAIL parity_done k=%0d got %b want %b", k, tx_done, k == 176);
      end
      nchk++;
      if (tx_ready !== (k == 177)) begin
        nfail++; $display("FAIL parity_ready k=%0d got %b want %b", k, tx_ready, k == 177);
      end
    end
  endtask
`endif

  task automatic test_loopback();
    logic [7:0] sent[$];
    logic [7:0] b;
    int w;
    rx_q.delete();
    rx_ferr = 0;
    done_cnt = 0;
    mon_en = 1'b1;
    for (int n = 0; n < 256; n++) begin
      b = 8'($urandom_range(0, 255));
      sent.push_back(b);
      tx_data = b;
      tx_valid = 1'b1;
      w = 0;
      while (tx_ready !== 1'b1 && w < 400) begin
        @(posedge clk); #1;
        w++;
      end
      if (tx_ready !== 1'b1) begin
        nchk++;
        nfail++; $display("FAIL loop_ready_timeout n=%0d got %b want 1", n, tx_ready);
        break;
      end
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    repeat (P + 20) @(posedge clk);
    #1;
    mon_en = 1'b0;
    nchk++;
    if (rx_q.size() != sent.size()) begin
      nfail++; $display("FAIL loop_count got %0d want %0d", rx_q.size(), sent.size());
    end
    for (int i = 0; i < sent.size() && i < rx_q.size(); i++) begin
      nchk++;
      if (rx_q[i] !== sent[i]) begin
        nfail++; $display("FAIL loop_byte i=%0d got %h want %h", i, rx_q[i], sent[i]);
      end
    end
    nchk++;
    if (rx_ferr != 0) begin
      nfail++; $display("FAIL loop_frame_err got %0d want 0", rx_ferr);
    end
    nchk++;
    if (done_cnt != sent.size()) begin
      nfail++; $display("FAIL loop_done_count got %0d want %0d", done_cnt, sent.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_valid();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
